// File: rtl/volume_ramp_control_if.sv
// Control bundle between the button/tick front end and the volume ramp block.
// The ramp block takes the slave side; its user takes the master side.
interface volume_ramp_control_if #(
  parameter int AUDIO_W = 16,
  parameter int LEVEL_W = 4
);
  logic               tick;
  logic               vol_up;
  logic               vol_down;
  logic               mute_toggle;
  logic [LEVEL_W-1:0] level;
  logic               muted;
  logic               ramping;
  logic [AUDIO_W-1:0] audio_max;
  logic [AUDIO_W-1:0] audio_min;

  modport master (
    output tick, vol_up, vol_down, mute_toggle,
    input  level, muted, ramping, audio_max, audio_min
  );

  modport slave (
    input  tick, vol_up, vol_down, mute_toggle,
    output level, muted, ramping, audio_max, audio_min
  );
endinterface

// File: rtl/volume_ramp_control.sv
// Saturating volume level with mute; the output amplitude slews toward the
// level's target by at most RAMP_STEP per tick so changes never click.
module volume_ramp_control #(
  parameter int AUDIO_W   = 16,
  parameter int LEVEL_W   = 4,
  parameter int MAX_LEVEL = 15,
  parameter int STEP      = 1400,
  parameter int RAMP_STEP = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  volume_ramp_control_if.slave bus
);

  // One spare bit so target and distance arithmetic never wraps.
  localparam int CALC_W = AUDIO_W + 1;

  typedef enum logic [1:0] {
    RAMP_HOLD,
    RAMP_RISE,
    RAMP_FALL
  } ramp_dir_t;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               muted_q, muted_d;
  logic [AUDIO_W-1:0] cur_q, cur_d;
  logic [CALC_W-1:0]  target;
  logic [CALC_W-1:0]  cur_ext;
  logic [CALC_W-1:0]  gap;
  ramp_dir_t          ramp_dir;

  always_comb begin
    level_d = level_q;
    if (bus.vol_up && !bus.vol_down && level_q != LEVEL_W'(MAX_LEVEL)) begin
      level_d = level_q + 1'b1;
    end else if (bus.vol_down && !bus.vol_up && level_q != '0) begin
      level_d = level_q - 1'b1;
    end
    muted_d = muted_q ^ bus.mute_toggle;
  end

  always_comb begin
    target = '0;
    if (!muted_q) begin
      target = CALC_W'(STEP) * (CALC_W'(level_q) + CALC_W'(1));
    end
  end

  assign cur_ext = {1'b0, cur_q};

  always_comb begin
    ramp_dir = RAMP_HOLD;
    gap      = '0;
    if (cur_ext < target) begin
      ramp_dir = RAMP_RISE;
      gap      = target - cur_ext;
    end else if (cur_ext > target) begin
      ramp_dir = RAMP_FALL;
      gap      = cur_ext - target;
    end
  end

  // Land exactly on the target once it is within one step.
  always_comb begin
    cur_d = cur_q;
    if (bus.tick) begin
      case (ramp_dir)
        RAMP_RISE: cur_d = (gap > CALC_W'(RAMP_STEP)) ? cur_q + AUDIO_W'(RAMP_STEP)
                                                     : target[AUDIO_W-1:0];
        RAMP_FALL: cur_d = (gap > CALC_W'(RAMP_STEP)) ? cur_q - AUDIO_W'(RAMP_STEP)
                                                     : target[AUDIO_W-1:0];
        default:   cur_d = cur_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      muted_q <= 1'b0;
      cur_q   <= AUDIO_W'(STEP);
    end else begin
      level_q <= level_d;
      muted_q <= muted_d;
      cur_q   <= cur_d;
    end
  end

  assign bus.level     = level_q;
  assign bus.muted     = muted_q;
  assign bus.audio_max = cur_q;
  assign bus.audio_min = '0 - cur_q;
  assign bus.ramping   = (cur_ext != target);

endmodule
